// File: rtl/dispatch_pkg.sv
// Shared definitions for the round-robin dispatcher: channel geometry,
// FSM state encoding and the round-robin channel pick function.
package dispatch_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int STAT_W = 8;

    typedef enum logic {
        ST_EMPTY,
        ST_HOLD
    } state_t;

    // First enabled channel scanning upward from ptr+1, wrapping modulo 4.
    // With an empty mask the pointer is returned unchanged; the caller
    // never accepts in that case, so the value is never used.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_CH-1:0] mask,
                                                 input logic [SEL_W-1:0]  ptr);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && mask[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/demux4_steer.sv
// Combinational 1:4 demux: routes the held word and its valid bit onto the
// lane chosen by sel. Unselected lanes are driven to zero.
import dispatch_pkg::*;

module demux4_steer #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]        data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    valid,
    output logic [NUM_CH-1:0]       lane_valid,
    output logic [NUM_CH*WIDTH-1:0] lane_data
);

    // Zero every lane, then place the word and valid bit on the selected one.
    always_comb begin
        lane_valid                   = '0;
        lane_data                    = '0;
        lane_valid[sel]              = valid;
        lane_data[sel*WIDTH +: WIDTH] = data;
    end

endmodule

// File: rtl/demux4_rr_dispatch.sv
// Round-robin dispatcher: registers one word from a single valid/ready
// producer and steers it to the next enabled consumer channel, holding it
// there until that channel takes it.
// Optional per-channel delivered-word counters are built when the macro
// DISPATCH_STATS_EN is defined; otherwise stat_cnt is tied to zero.
import dispatch_pkg::*;

module demux4_rr_dispatch #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [NUM_CH-1:0]        ch_en,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*WIDTH-1:0]  out_data,
    output logic [SEL_W-1:0]         cur_sel,
    input  logic                     stat_clr,
    output logic [NUM_CH*STAT_W-1:0] stat_cnt
);

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] pick;
    logic [WIDTH-1:0] data_q;
    logic             hold;
    logic             drain;
    logic             accept;

    assign hold     = (state == ST_HOLD);
    assign drain    = hold & out_ready[sel_q];
    assign in_ready = (!hold | drain) & (ch_en != '0);
    assign accept   = in_valid & in_ready;
    assign pick     = rr_pick(ch_en, ptr);
    assign cur_sel  = sel_q;

    // State register; reset discards any held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a new word can be taken whenever the slot is empty or
    // the held word leaves in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (drain && !accept) begin
                    state_nxt = ST_EMPTY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // Word, destination and rotation pointer load only on accept, so a
    // held word keeps its channel regardless of later ch_en changes.
    // The pointer resets to 3 so the first pick scans from channel 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= SEL_W'(NUM_CH - 1);
            sel_q  <= '0;
            data_q <= '0;
        end else if (accept) begin
            ptr    <= pick;
            sel_q  <= pick;
            data_q <= in_data;
        end
    end

    demux4_steer #(
        .WIDTH (WIDTH)
    ) u_steer (
        .data       (data_q),
        .sel        (sel_q),
        .valid      (hold),
        .lane_valid (out_valid),
        .lane_data  (out_data)
    );

`ifdef DISPATCH_STATS_EN
    logic [STAT_W-1:0] stat_q [NUM_CH];

    // Saturating delivered-word counters; a clear beats a same-cycle drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (stat_clr) begin
                    stat_q[i] <= '0;
                end else if (drain && (sel_q == SEL_W'(i)) && (stat_q[i] != {STAT_W{1'b1}})) begin
                    stat_q[i] <= stat_q[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_stat
        assign stat_cnt[g*STAT_W +: STAT_W] = stat_q[g];
    end
`else
    logic unused_stat_clr;

    assign unused_stat_clr = stat_clr;
    assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_demux4_rr_dispatch.sv
// Directed self-checking bench for demux4_rr_dispatch. Inputs change at the
// falling edge; outputs are sampled at the falling edge or 1ns after a
// change to inputs, away from the rising edge.
module tb_demux4_rr_dispatch;

    localparam int WIDTH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic [3:0]        ch_en;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [1:0]        cur_sel;
    logic              stat_clr;
    logic [31:0]       stat_cnt;

    int checks = 0;
    int errors = 0;

    demux4_rr_dispatch #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ch_en     (ch_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cur_sel   (cur_sel),
        .stat_clr  (stat_clr),
        .stat_cnt  (stat_cnt)
    );

    // 10ns free-running clock.
    always #5 clk = ~clk;

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        ch_en     = 4'b1111;
        out_ready = 4'b1111;
        stat_clr  = 1'b0;
        #12;
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %b expected %b", out_valid, 4'b0000);
        end
        checks++;
        if (out_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_out_data: got %h expected %h", out_data, 32'h0);
        end
        checks++;
        if (cur_sel !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_cur_sel: got %0d expected %0d", cur_sel, 0);
        end
        checks++;
        if (stat_cnt !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_stat_cnt: got %h expected %h", stat_cnt, 32'h0);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b expected %b", in_ready, 1'b1);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_rotation();
        logic [7:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic [1:0] chans [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        ch_en     = 4'b1111;
        out_ready = 4'b1111;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (out_valid !== (4'b0001 << chans[k-1])) begin
                    errors++;
                    $display("[TB] FAIL rot_valid[%0d]: got %b expected %b", k-1, out_valid, 4'b0001 << chans[k-1]);
                end
                checks++;
                if (out_data[chans[k-1]*8 +: 8] !== words[k-1]) begin
                    errors++;
                    $display("[TB] FAIL rot_data[%0d]: got %h expected %h", k-1, out_data[chans[k-1]*8 +: 8], words[k-1]);
                end
                checks++;
                if (cur_sel !== chans[k-1]) begin
                    errors++;
                    $display("[TB] FAIL rot_sel[%0d]: got %0d expected %0d", k-1, cur_sel, chans[k-1]);
                end
            end
            if (k < 5) begin
                in_valid = 1'b1;
                in_data  = words[k];
                #1;
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL rot_ready[%0d]: got %b expected %b", k, in_ready, 1'b1);
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL rot_empty: got %b expected %b", out_valid, 4'b0000);
        end
    endtask

    task automatic test_sparse_mask();
        logic [7:0] words [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        logic [1:0] chans [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
        ch_en     = 4'b1010;
        out_ready = 4'b1111;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (out_valid !== (4'b0001 << chans[k-1])) begin
                    errors++;
                    $display("[TB] FAIL sparse_valid[%0d]: got %b expected %b", k-1, out_valid, 4'b0001 << chans[k-1]);
                end
                checks++;
                if (out_data[chans[k-1]*8 +: 8] !== words[k-1]) begin
                    errors++;
                    $display("[TB] FAIL sparse_data[%0d]: got %h expected %h", k-1, out_data[chans[k-1]*8 +: 8], words[k-1]);
                end
            end
            if (k < 4) begin
                in_valid = 1'b1;
                in_data  = words[k];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL sparse_empty: got %b expected %b", out_valid, 4'b0000);
        end
    endtask

    task automatic test_stall();
        // Pointer is at 3; only channel 2 enabled forces 0x5A onto ch2.
        ch_en     = 4'b0100;
        out_ready = 4'b1011;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        @(negedge clk);
        ch_en   = 4'b1111;
        in_data = 8'h6B;
        #1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 4'b0100 || out_data[23:16] !== 8'h5A || cur_sel !== 2'd2) begin
                errors++;
                $display("[TB] FAIL stall_hold[%0d]: got valid %b lane2 %h sel %0d expected valid %b lane2 %h sel %0d",
                         c, out_valid, out_data[23:16], cur_sel, 4'b0100, 8'h5A, 2);
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_ready[%0d]: got %b expected %b", c, in_ready, 1'b0);
            end
            @(negedge clk);
            #1;
        end
        out_ready = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_release_ready: got %b expected %b", in_ready, 1'b1);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 4'b1000 || out_data[31:24] !== 8'h6B) begin
            errors++;
            $display("[TB] FAIL stall_next_word: got valid %b lane3 %h expected valid %b lane3 %h",
                     out_valid, out_data[31:24], 4'b1000, 8'h6B);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL stall_empty: got %b expected %b", out_valid, 4'b0000);
        end
    endtask

    task automatic test_enable_change();
        ch_en     = 4'b0100;
        out_ready = 4'b1011;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        @(negedge clk);
        in_valid = 1'b0;
        ch_en    = 4'b1011;
        @(negedge clk);
        checks++;
        if (out_valid !== 4'b0100 || out_data[23:16] !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL en_clear_hold: got valid %b lane2 %h expected valid %b lane2 %h",
                     out_valid, out_data[23:16], 4'b0100, 8'h5A);
        end
        in_valid  = 1'b1;
        in_data   = 8'h77;
        out_ready = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL en_drain_ready: got %b expected %b", in_ready, 1'b1);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 4'b1000 || out_data[31:24] !== 8'h77) begin
            errors++;
            $display("[TB] FAIL en_next_ch3: got valid %b lane3 %h expected valid %b lane3 %h",
                     out_valid, out_data[31:24], 4'b1000, 8'h77);
        end
        ch_en   = 4'b0000;
        in_data = 8'h88;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL en_zero_ready: got %b expected %b", in_ready, 1'b0);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL en_zero_drain: got %b expected %b", out_valid, 4'b0000);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL en_zero_ready_empty: got %b expected %b", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        ch_en    = 4'b1111;
    endtask

    task automatic test_reset_hold();
        ch_en     = 4'b1111;
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = 8'h99;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 4'b0001 || out_data[7:0] !== 8'h99) begin
            errors++;
            $display("[TB] FAIL rsthold_pre: got valid %b lane0 %h expected valid %b lane0 %h",
                     out_valid, out_data[7:0], 4'b0001, 8'h99);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 4'b0000 || out_data !== 32'h0 || cur_sel !== 2'd0) begin
            errors++;
            $display("[TB] FAIL rsthold_async: got valid %b data %h sel %0d expected valid %b data %h sel %0d",
                     out_valid, out_data, cur_sel, 4'b0000, 32'h0, 0);
        end
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_data   = 8'hAB;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 4'b0001 || out_data[7:0] !== 8'hAB) begin
            errors++;
            $display("[TB] FAIL rsthold_first: got valid %b lane0 %h expected valid %b lane0 %h",
                     out_valid, out_data[7:0], 4'b0001, 8'hAB);
        end
        @(negedge clk);
    endtask

    task automatic test_stats();
`ifdef DISPATCH_STATS_EN
        logic [31:0] exp_one_ch0 = 32'h0000_0001;
        logic [31:0] exp_nine    = 32'h0000_0900;
        logic [31:0] exp_sat     = 32'h0000_FF00;
        logic [31:0] exp_one_ch1 = 32'h0000_0100;
`else
        logic [31:0] exp_one_ch0 = 32'h0;
        logic [31:0] exp_nine    = 32'h0;
        logic [31:0] exp_sat     = 32'h0;
        logic [31:0] exp_one_ch1 = 32'h0;
`endif
        // The word 0xAB delivered after the last reset counts on ch0.
        checks++;
        if (stat_cnt !== exp_one_ch0) begin
            errors++;
            $display("[TB] FAIL stat_after_reset: got %h expected %h", stat_cnt, exp_one_ch0);
        end
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        checks++;
        if (stat_cnt !== 32'h0) begin
            errors++;
            $display("[TB] FAIL stat_clear: got %h expected %h", stat_cnt, 32'h0);
        end
        // Stream to ch1 only: after n edges with a word on offer, n-1 drains.
        ch_en     = 4'b0010;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_data   = 8'h01;
        repeat (10) @(negedge clk);
        checks++;
        if (stat_cnt !== exp_nine) begin
            errors++;
            $display("[TB] FAIL stat_count9: got %h expected %h", stat_cnt, exp_nine);
        end
        repeat (290) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (stat_cnt !== exp_sat) begin
            errors++;
            $display("[TB] FAIL stat_saturate: got %h expected %h", stat_cnt, exp_sat);
        end
        // Clear in the same cycle as a drain on ch1.
        in_valid = 1'b1;
        in_data  = 8'hC3;
        @(negedge clk);
        in_valid = 1'b0;
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        checks++;
        if (stat_cnt !== 32'h0 || out_valid !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL stat_clr_priority: got cnt %h valid %b expected cnt %h valid %b",
                     stat_cnt, out_valid, 32'h0, 4'b0000);
        end
        in_valid = 1'b1;
        in_data  = 8'hC4;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (stat_cnt !== exp_one_ch1) begin
            errors++;
            $display("[TB] FAIL stat_recount: got %h expected %h", stat_cnt, exp_one_ch1);
        end
    endtask

    // Scenario sequence; each task checks its own expectations inline.
    initial begin
        test_reset();
        test_rotation();
        test_sparse_mask();
        test_stall();
        test_enable_change();
        test_reset_hold();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux4_rr_dispatch.md
# demux4_rr_dispatch

Round-robin dispatcher that sequences the 1:4 demux select so a single valid/ready input stream is distributed over four output channels. Each accepted word is registered and steered through a 1:4 demux to the next enabled channel in rotation. The held word stays on that channel until the channel accepts it. The block sits between a single producer and four parallel consumer lanes, and replaces static `sel` driving of the combinational demux.

## Interface
Parameters:
- `WIDTH`, 8, data word width in bits.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  producer has a word.
- `in_ready`  out  1  dispatcher accepts the word this cycle.
- `in_data`  in  WIDTH  producer word.
- `ch_en`  in  4  channel enable mask; bit i enables channel i for new assignments.
- `out_valid`  out  4  one-hot valid for the channel holding the word; all zero when empty.
- `out_ready`  in  4  per-channel consumer ready.
- `out_data`  out  4*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]. The selected lane carries the held word; the other lanes are 0.
- `cur_sel`  out  2  channel index of the held word.
- `stat_clr`  in  1  synchronous clear of the statistics counters.
- `stat_cnt`  out  32  four 8-bit delivered-word counters; channel i occupies bits [i*8 +: 8].

## Operation
- Two-state FSM:
  - EMPTY: no word held.
  - HOLD: one word is registered in `data_q` with destination `sel_q`.
- `drain` = HOLD & `out_ready[sel_q]`.
- `accept` = `in_valid` & `in_ready`.
- `in_ready` = (EMPTY | `drain`) & (`ch_en` != 0). It does not depend on `out_ready` of any channel other than `sel_q`.
- Channel pick on accept: the first enabled channel scanning upward from `ptr`+1, wrapping modulo 4.
  - On accept: `sel_q` <= pick, `ptr` <= pick, `data_q` <= `in_data`.
- Transitions:
  - EMPTY & accept -> HOLD.
  - HOLD & drain & accept -> HOLD, loaded with the new word and channel.
  - HOLD & drain & !accept -> EMPTY.
  - HOLD & !drain -> HOLD, with `data_q` and `sel_q` unchanged.
- The held word is never reassigned. Clearing its `ch_en` bit while in HOLD has no effect until the word drains. `ch_en` affects only the next pick.
- If `ch_en` is 0, the block accepts nothing, and any held word still drains normally.
- `out_valid` = HOLD ? onehot(`sel_q`) : 0. `out_data` is the registered `data_q` steered through the 1:4 demux by `sel_q`.
- `cur_sel` = `sel_q` in all states.

## Timing
- Reset values:
  - state EMPTY.
  - `ptr` = 3, so the first word goes to the lowest enabled channel starting at channel 0.
  - `sel_q` = 0, `data_q` = 0.
  - `out_valid` = 0, `out_data` = 0, `cur_sel` = 0, `stat_cnt` = 0.
  - `in_ready` follows its equation and is 1 after reset if `ch_en` != 0.
- Latency: a word accepted at edge N presents `out_valid` from edge N through the cycle of its drain, so it is visible the cycle after acceptance.
- Throughput: one word per cycle when every targeted channel is ready.
- Reset asserted mid-HOLD discards the held word immediately (asynchronous); no partial delivery.

## Configuration
- `DISPATCH_STATS_EN` defined:
  - Each `stat_cnt` lane increments by 1 on every drain to that channel.
  - Each lane saturates at 255.
  - `stat_clr` zeroes all four lanes on the next edge; clear has priority over a simultaneous increment.
- `DISPATCH_STATS_EN` undefined:
  - No counter logic is generated.
  - `stat_cnt` is tied to 0 and `stat_clr` is ignored.
  - The port list is identical in both builds.

## Structure
- Package `dispatch_pkg` holds:
  - `NUM_CH` = 4.
  - `SEL_W` = 2.
  - `STAT_W` = 8.
  - The state enum: `ST_EMPTY`, `ST_HOLD`.
  - The round-robin pick function (mask, pointer -> index).
- Sub-module `demux4_steer`: combinational 1:4 steering of `data_q` and of the valid bit by `sel_q`. Unselected outputs are 0.
- Top level contains the FSM, pointer, data register and optional stats.

## Test plan
- Reset, `ch_en`=4'b1111, all `out_ready`=1, stream 0x11,0x22,0x33,0x44,0x55 -> delivered to channels 0,1,2,3,0 on consecutive cycles; `in_ready` stays 1.
- `ch_en`=4'b1010, stream 0xA0..0xA3 -> channels 1,3,1,3; `out_valid` never asserts bits 0 or 2.
- Word 0x5A assigned to ch2 with `out_ready[2]`=0 for 5 cycles -> `out_valid`=4'b0100 and lane 2 = 0x5A held stable, `in_ready`=0. Raising `out_ready[2]` drains it and accepts the next word the same cycle.
- Clear `ch_en[2]` while 0x5A is held on ch2 -> it still drains to ch2; the next word goes to ch3. With `ch_en`=0, `in_ready`=0.
- Assert `rst` during HOLD -> `out_valid`=0 and `out_data`=0 immediately. After release, the first word goes to ch0.
- With `DISPATCH_STATS_EN`: 300 drains to ch1 -> `stat_cnt[15:8]`=255. `stat_clr` concurrent with a drain -> 0. Without the macro: `stat_cnt`=0 throughout.
